vgagraph_rdarb: RTL and testbench
=================================

# vgagraph_rdarb

Read-channel arbiter for the VGA graphics memory port. It shares the single AXI read channel between the display line-fill requester (high priority) and the draw-engine requester (low priority). Each winning request becomes one fixed-length burst on AR. Returning R beats are routed to their owner through an in-order owner queue. The block sits between the line-fill sequencer / draw engine and the AXI HP master port.

## Interface
Parameters:
- ADDR_W, 32, AXI address width
- BURST_LEN, 16, beats per burst; ARLEN is driven as BURST_LEN-1
- MAX_OUTST, 4, maximum outstanding bursts (power of two, 2..16)
- STARVE_LIM, 8, consecutive display grants allowed while draw is waiting

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- disp_req  in  1  display burst request, held until disp_gnt
- disp_addr  in  ADDR_W  display burst start address, stable while disp_req
- disp_gnt  out  1  one-cycle pulse on the AR handshake of a display burst
- draw_req  in  1  draw-engine burst request, held until draw_gnt
- draw_addr  in  ADDR_W  draw burst start address
- draw_gnt  out  1  one-cycle pulse on the AR handshake of a draw burst
- araddr  out  ADDR_W  AXI read address
- arlen  out  8  constant BURST_LEN-1
- arvalid  out  1  AXI address valid
- arready  in  1  AXI address ready
- rvalid  in  1  AXI read data valid
- rlast  in  1  AXI last beat
- rready  out  1  AXI read ready
- disp_rvalid  out  1  beat belongs to display
- disp_rready  in  1  display can accept a beat
- draw_rvalid  out  1  beat belongs to draw
- draw_rready  in  1  draw engine can accept a beat
- busy  out  1  outstanding count is non-zero or arvalid is high

## Operation
- FSM states: IDLE and ADDR.
- IDLE → ADDR when a request is pending and outst < MAX_OUTST. On that transition:
  - araddr and the owner are registered.
  - arvalid is set.
- ADDR holds arvalid, araddr and the owner stable until arready.
- On the arready cycle:
  - arvalid is cleared.
  - The owner's gnt pulses.
  - The owner is pushed to the queue.
  - outst is incremented.
  - The state returns to IDLE.
- Selection rule: display wins, except when draw_req is high and starve_cnt == STARVE_LIM; then draw wins.
- starve_cnt:
  - Increments on each display grant while draw_req is high, saturating at STARVE_LIM.
  - Clears on any draw grant.
  - Clears while draw_req is low.
- Owner queue: depth MAX_OUTST, 1 bit per entry (0 = display, 1 = draw). It cannot overflow because issue is gated by outst.
- R routing is combinational from the queue head:
  - head=0: disp_rvalid = rvalid and rready = disp_rready.
  - head=1: draw_rvalid = rvalid and rready = draw_rready.
  - Queue empty: rready=0 and both rvalid outputs are 0.
- Beat handshake with rlast high pops the queue and decrements outst.
- A push and a pop in the same cycle leave outst unchanged and keep the queue consistent.
- Width rules:
  - outst has clog2(MAX_OUTST)+1 bits.
  - starve_cnt has clog2(STARVE_LIM+1) bits.
  - Address has no arithmetic; it is passed through.

## Timing
- Reset values: arvalid=0, araddr=0, disp_gnt=0, draw_gnt=0, busy=0, state=IDLE, outst=0, starve_cnt=0, queue empty. Hence rready=0, disp_rvalid=0, draw_rvalid=0.
- Request-to-arvalid latency: 1 cycle (req seen in IDLE → arvalid high the next cycle).
- Minimum AR spacing: 2 cycles. arready in the first ADDR cycle gives back-to-back issue every 2 cycles.
- gnt is coincident with the arvalid&&arready cycle. The requester may drop req or change addr in the following cycle.
- A request dropped before gnt is a protocol violation, and the bench flags it. After arvalid rises, the AR beat is still completed.
- When outst == MAX_OUTST, requests stall in IDLE. Issue resumes in the cycle after the rlast handshake that makes outst < MAX_OUTST.
- The R path has zero latency (combinational routing). No data passes through the block.
- RST mid-burst drops all state immediately. The AXI slave must be reset by the same RST.

## Structure
- Shared package vgagraph_pkg holds:
  - Owner encoding constants: OWN_DISP=0, OWN_DRAW=1.
  - The BURST_LEN default.
  - FSM state localparams.
- One sub-module: vgagraph_ownq, a 1-bit synchronous FIFO with parameterised depth and push/pop/empty/full.
- The arbiter FSM, starvation counter and outst counter stay in the top level.

## Test plan
- Single display request at 0x1000_0000, arready after 2 cycles: araddr=0x1000_0000, arlen=15, and disp_gnt is a single pulse. 16 R beats go to disp_rvalid only; rlast returns busy to 0.
- Both requesting every cycle, STARVE_LIM=8, arready=1: the grant sequence is 8 display, 1 draw, repeating, and starve_cnt clears after each draw grant.
- MAX_OUTST=4 with R withheld: exactly 4 AR handshakes, then arvalid stays 0. The first rlast allows the 5th issue one cycle later.
- Interleaved owners D,W,D outstanding with R beats returned in order: beats steer to disp, draw, disp. rready follows the owning *_rready (backpressure on draw_rready=0 stalls only the second burst).
- Push and pop in the same cycle (arready and rlast handshake together): outst unchanged and queue order preserved.
- RST asserted while arvalid=1 and 2 bursts are outstanding: next cycle arvalid=0, busy=0, rready=0, with no gnt pulse.

Source files
------------

// File: rtl/vgagraph_pkg.sv
// Shared definitions for the VGA graphics read-channel arbiter.
// Owner encoding is also the bit stored in the in-order owner queue.
package vgagraph_pkg;

    localparam logic OWN_DISP = 1'b0;
    localparam logic OWN_DRAW = 1'b1;

    localparam int unsigned BURST_LEN_DEF = 16;

    typedef enum logic {
        StIdle,
        StAddr
    } rdarb_state_e;

endpackage

// File: rtl/vgagraph_ownq.sv
// One-bit synchronous FIFO recording which requester owns each outstanding burst.
// Depth must be a power of two so the pointers wrap naturally.
module vgagraph_ownq #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic data_i,
    input  logic pop_i,
    output logic head_o,
    output logic empty_o,
    output logic full_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign head_o  = mem_q[rd_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok) begin
            mem_d[wr_q] = data_i;
            wr_d        = wr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_d = rd_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vgagraph_rdarb.sv
// Shares one AXI read channel between display line-fill (priority) and draw engine,
// issuing one fixed-length burst per grant and steering R beats back to their owner.
module vgagraph_rdarb
    import vgagraph_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned BURST_LEN  = BURST_LEN_DEF,
    parameter int unsigned MAX_OUTST  = 4,
    parameter int unsigned STARVE_LIM = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    input  logic              draw_req,
    input  logic [ADDR_W-1:0] draw_addr,
    output logic              draw_gnt,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic              arvalid,
    input  logic              arready,
    input  logic              rvalid,
    input  logic              rlast,
    output logic              rready,
    output logic              disp_rvalid,
    input  logic              disp_rready,
    output logic              draw_rvalid,
    input  logic              draw_rready,
    output logic              busy
);

    localparam int unsigned OW = $clog2(MAX_OUTST) + 1;
    localparam int unsigned SW = $clog2(STARVE_LIM + 1);
    localparam logic [OW-1:0] OUTST_MAX  = OW'(MAX_OUTST);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

    rdarb_state_e      state_q, state_d;
    logic              arvalid_q, arvalid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              own_q, own_d;
    logic [OW-1:0]     outst_q, outst_d;
    logic [SW-1:0]     starve_q, starve_d;

    logic ar_hs, r_pop, pick_draw, can_issue;
    logic q_head, q_empty, q_full;

    assign ar_hs     = arvalid_q && arready;
    assign r_pop     = rvalid && rready && rlast;
    assign can_issue = (outst_q < OUTST_MAX) && !q_full;
    // Draw only overrides display once it has watched STARVE_LIM display grants go by.
    assign pick_draw = draw_req && (!disp_req || starve_q == STARVE_MAX);

    assign arvalid  = arvalid_q;
    assign araddr   = araddr_q;
    assign arlen    = 8'(BURST_LEN - 1);
    assign disp_gnt = ar_hs && (own_q == OWN_DISP);
    assign draw_gnt = ar_hs && (own_q == OWN_DRAW);
    assign busy     = (outst_q != '0) || arvalid_q;

    vgagraph_ownq #(
        .DEPTH (MAX_OUTST)
    ) u_ownq (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (ar_hs),
        .data_i  (own_q),
        .pop_i   (r_pop),
        .head_o  (q_head),
        .empty_o (q_empty),
        .full_o  (q_full)
    );

    always_comb begin
        disp_rvalid = 1'b0;
        draw_rvalid = 1'b0;
        rready      = 1'b0;
        if (!q_empty) begin
            if (q_head == OWN_DRAW) begin
                draw_rvalid = rvalid;
                rready      = draw_rready;
            end else begin
                disp_rvalid = rvalid;
                rready      = disp_rready;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        own_d     = own_q;
        case (state_q)
            StIdle: begin
                if ((disp_req || draw_req) && can_issue) begin
                    state_d   = StAddr;
                    arvalid_d = 1'b1;
                    own_d     = pick_draw ? OWN_DRAW : OWN_DISP;
                    araddr_d  = pick_draw ? draw_addr : disp_addr;
                end
            end
            StAddr: begin
                if (arready) begin
                    state_d   = StIdle;
                    arvalid_d = 1'b0;
                end
            end
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!draw_req || draw_gnt) begin
            starve_d = '0;
        end else if (disp_gnt && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        case ({ar_hs, r_pop})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            own_q     <= OWN_DISP;
            outst_q   <= '0;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            own_q     <= own_d;
            outst_q   <= outst_d;
            starve_q  <= starve_d;
        end
    end

endmodule

// File: tb/tb_vgagraph_rdarb.sv
// Randomised bench for vgagraph_rdarb against a transaction-level reference model
// (owner queue, starvation count, one pending AR) plus a simple AXI read slave.
module tb_vgagraph_rdarb;

    localparam int unsigned AW = 32;
    localparam int unsigned BL = 16;
    localparam int unsigned MO = 4;
    localparam int unsigned SL = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          disp_req, draw_req, disp_gnt, draw_gnt;
    logic [AW-1:0] disp_addr, draw_addr, araddr;
    logic [7:0]    arlen;
    logic          arvalid, arready, rvalid, rlast, rready;
    logic          disp_rvalid, disp_rready, draw_rvalid, draw_rready, busy;

    always #5 CLK = ~CLK;

    vgagraph_rdarb #(
        .ADDR_W     (AW),
        .BURST_LEN  (BL),
        .MAX_OUTST  (MO),
        .STARVE_LIM (SL)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_gnt    (disp_gnt),
        .draw_req    (draw_req),
        .draw_addr   (draw_addr),
        .draw_gnt    (draw_gnt),
        .araddr      (araddr),
        .arlen       (arlen),
        .arvalid     (arvalid),
        .arready     (arready),
        .rvalid      (rvalid),
        .rlast       (rlast),
        .rready      (rready),
        .disp_rvalid (disp_rvalid),
        .disp_rready (disp_rready),
        .draw_rvalid (draw_rvalid),
        .draw_rready (draw_rready),
        .busy        (busy)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit            m_arv;
    logic [AW-1:0] m_addr;
    bit            m_own;
    bit            m_q[$];
    int            m_starve;
    bit            glog[$];

    // AXI slave and requester state
    int s_bursts, s_beat;
    bit s_rv;
    bit got_dg, got_wg;

    int p_req, p_ard, p_rv, p_rr;
    bit always_req;

    function automatic bit chance(input int p);
        return (int'($urandom_range(99)) < p);
    endfunction

    task automatic model_reset();
        m_arv    = 0;
        m_addr   = '0;
        m_own    = 0;
        m_q.delete();
        m_starve = 0;
        s_bursts = 0;
        s_beat   = 0;
        s_rv     = 0;
        got_dg   = 0;
        got_wg   = 0;
    endtask

    task automatic drive();
        if (!(disp_req && !got_dg)) begin
            disp_req = always_req || chance(p_req);
            if (disp_req) disp_addr = $urandom;
        end
        if (!(draw_req && !got_wg)) begin
            draw_req = always_req || chance(p_req);
            if (draw_req) draw_addr = $urandom;
        end
        arready = chance(p_ard);
        if (s_bursts > 0) begin
            if (!s_rv) s_rv = chance(p_rv);
        end else begin
            s_rv = 0;
        end
        rvalid      = s_rv;
        rlast       = s_rv && (s_beat == BL - 1);
        disp_rready = chance(p_rr);
        draw_rready = chance(p_rr);
    endtask

    task automatic check_outputs();
        bit ne, hd, e_rr, e_dv, e_wv;
        ne = (m_q.size() > 0);
        hd = 0;
        if (ne) hd = m_q[0];
        e_rr = ne && (hd ? draw_rready : disp_rready);
        e_dv = ne && !hd && rvalid;
        e_wv = ne && hd && rvalid;
        check_eq("arvalid", arvalid, m_arv);
        check_eq("araddr", araddr, m_addr);
        check_eq("arlen", arlen, BL - 1);
        check_eq("disp_gnt", disp_gnt, m_arv && arready && !m_own);
        check_eq("draw_gnt", draw_gnt, m_arv && arready && m_own);
        check_eq("busy", busy, ne || m_arv);
        check_eq("rready", rready, e_rr);
        check_eq("disp_rvalid", disp_rvalid, e_dv);
        check_eq("draw_rvalid", draw_rvalid, e_wv);
        got_dg = disp_gnt;
        got_wg = draw_gnt;
    endtask

    task automatic model_update();
        int sz;
        bit rr;
        sz = m_q.size();
        rr = 0;
        if (sz > 0) rr = m_q[0] ? draw_rready : disp_rready;
        if (rr && rvalid && rlast) void'(m_q.pop_front());
        if (m_arv) begin
            if (arready) begin
                m_q.push_back(m_own);
                glog.push_back(m_own);
                if (m_own) m_starve = 0;
                else if (draw_req && m_starve < SL) m_starve++;
                m_arv = 0;
            end
        end else if ((disp_req || draw_req) && sz < MO) begin
            m_arv  = 1;
            m_own  = draw_req && (!disp_req || m_starve == SL);
            m_addr = m_own ? draw_addr : disp_addr;
        end
        if (!draw_req) m_starve = 0;
        // Slave reacts to the real bus so the bench keeps running if the DUT misbehaves.
        if (arvalid && arready) s_bursts++;
        if (rvalid && rready) begin
            s_rv = 0;
            if (s_beat == BL - 1) begin
                s_beat = 0;
                s_bursts--;
            end else begin
                s_beat++;
            end
        end
    endtask

    task automatic step();
        drive();
        #2;
        check_outputs();
        model_update();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_mode(input int pq, input int pa, input int pv, input int pr,
                            input bit ar);
        p_req = pq; p_ard = pa; p_rv = pv; p_rr = pr; always_req = ar;
    endtask

    initial begin
        int waited;
        RST = 1'b1;
        disp_req = 0; draw_req = 0; disp_addr = '0; draw_addr = '0;
        arready = 0; rvalid = 0; rlast = 0; disp_rready = 0; draw_rready = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_outputs();
        RST = 1'b0;

        // Saturated contention: grants must run 8 display, 1 draw, repeating.
        set_mode(100, 100, 100, 100, 1);
        glog.delete();
        repeat (700) step();
        check_eq("starve_grant_count_ge27", glog.size() >= 27, 1);
        for (int i = 0; i < 27 && i < glog.size(); i++) begin
            check_eq($sformatf("starve_seq[%0d]", i), glog[i], (i % 9) == 8);
        end

        set_mode(70, 50, 60, 70, 0);  repeat (800) step();
        set_mode(95, 100, 30, 50, 0); repeat (800) step();
        set_mode(40, 20, 90, 90, 0);  repeat (800) step();
        set_mode(90, 80, 5, 100, 0);  repeat (800) step();

        // Reset while an AR is pending with at least two bursts outstanding.
        set_mode(100, 30, 20, 100, 0);
        waited = 0;
        while (!(m_arv && m_q.size() >= 2) && waited < 3000) begin
            step();
            waited++;
        end
        check_eq("rst_setup_reached", waited < 3000, 1);
        drive();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
        rvalid = 0; rlast = 0; arready = 1; disp_rready = 1; draw_rready = 1;
        #1;
        check_eq("rst_arvalid", arvalid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rready", rready, 0);
        check_eq("rst_disp_gnt", disp_gnt, 0);
        check_eq("rst_draw_gnt", draw_gnt, 0);
        disp_req = 0; draw_req = 0;
        @(posedge CLK);
        #1;

        set_mode(80, 60, 70, 80, 0);
        repeat (600) step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
